ps2_frame_generator: RTL and testbench
======================================

// Module: ps2_frame_generator
// PURPOSE
//   Synthesizable PS/2 device-side transmitter: queues scan codes and serialises each as an 11-bit PS/2 frame.
//   Drives ps2_clk/ps2_data towards ps2_controller for in-system self-test and reusable bench stimulus.
//   Replaces hand-timed data toggling with parametrised timing, a FIFO and a valid/ready write port.
// PARAMETERS
//   CLK_FREQ_HZ   50_000_000  system clock frequency
//   PS2_FREQ_HZ   12_500      PS/2 bit rate; HALF = CLK_FREQ_HZ/(2*PS2_FREQ_HZ) = 2000 cycles at defaults
//   FIFO_DEPTH    8           scan-code queue depth, power of two, >= 2
//   GAP_BITS      8           idle bit periods after each stop bit (640 us at defaults)
// PORTS
//   clk           in   1   system clock
//   rst_n         in   1   asynchronous active-low reset
//   ena           in   1   1 = start new frames; 0 = finish current frame, then hold
//   wr_valid      in   1   scan-code write request
//   wr_data       in   8   scan code
//   wr_ready      out  1   = !full (combinational)
//   fifo_level    out  $clog2(FIFO_DEPTH)+1  queued codes, 0..FIFO_DEPTH
//   ps2_clk_out   out  1   generated PS/2 clock, idle high
//   ps2_data_out  out  1   generated PS/2 data, idle high
//   busy          out  1   high from LOAD through last GAP cycle
//   frame_done    out  1   one-cycle pulse at end of stop-bit slot
//   inj_par_err   in   1   only with PS2_PAR_ERR_INJ_EN
// BEHAVIOUR
//   Clock: one clk, rising edge. Reset: asynchronous, active low.
//   Reset (async, any state incl. mid-frame): ps2_clk_out=1, ps2_data_out=1, busy=0, frame_done=0,
//     fifo_level=0, wr_ready=1. FIFO contents discarded. Partial frame abandoned, never resumed.
//   Write: accepted on posedge when wr_valid && wr_ready. Writes while full are dropped (wr_ready=0).
//   Push and pop in the same cycle: both happen and level is unchanged. Push on the cycle a pop empties the FIFO is legal.
//   FSM: IDLE -> LOAD -> BIT -> GAP -> (LOAD if ena && !empty, else IDLE).
//     IDLE: leaves when ena && !empty. LOAD: pop one code and compute odd parity (1 cycle).
//     BIT: 11 slots (idx 0..10) = start 0, d[0]..d[7] LSB first, odd parity, stop 1.
//       Each slot is 2*HALF cycles: data updates at slot start, clk high HALF cycles, then low HALF cycles.
//       Device data is therefore stable across each falling edge.
//     GAP: clk=1, data=1 for GAP_BITS*2*HALF cycles.
//   Latency: code accepted into an empty FIFO in IDLE (ena=1) -> LOAD on the next cycle.
//     ps2_data_out falls 2 cycles after the accepting edge; first ps2_clk_out fall is HALF cycles later.
//   Frame period = (11+GAP_BITS)*2*HALF cycles (76_000 at defaults).
//   frame_done asserts on the last cycle of slot 10; ps2_clk_out returns high the same cycle.
//   ena falling mid-frame: frame and gap complete, then IDLE. ena only gates LOAD.
//   Counters: half-period counter is $clog2(HALF) bits and wraps at HALF-1. bit idx saturates at 10, no wrap.
//   Elaboration error if HALF < 2 or FIFO_DEPTH is not a power of two.
// CONFIGURATION
//   PS2_PAR_ERR_INJ_EN defined: adds port inj_par_err, sampled in LOAD; when 1, that frame's parity bit is inverted.
//   PS2_PAR_ERR_INJ_EN undefined: port absent and parity is always odd.
// STRUCTURE
//   ps2_pkg: PS2_FRAME_BITS=11, state encodings, odd_parity(byte) function.
//   Sub-module ps2_tx_fifo: synchronous FIFO with async reset and level output. FSM and timing stay in the top.
// TESTING
//   1. Write 0x1C, ena=1 -> bits sampled at clk falls = 0,0,0,1,1,1,0,0,0, parity 0, stop 1; frame_done x1.
//   2. Write 0x21,0xF0,0x5A back-to-back -> parities 1,1,1 in order; next start bit 76_000 cycles after previous.
//   3. Write 9 codes with ena=0 -> wr_ready=0 after 8th, 9th dropped, fifo_level=8. Set ena=1 -> 8 frames sent.
//   4. Assert rst_n low in slot 5 of 0x32 -> clk/data high immediately, level=0; no frame after release.
//   5. Drop ena in slot 3 with 2 codes queued -> current frame and gap finish, IDLE, fifo_level=1.
//   6. PS2_PAR_ERR_INJ_EN defined, inj_par_err=1, code 0x1C -> parity bit 1; ps2_controller flags parity error.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, FSM state encoding and parity helper for the PS/2 frame generator.
package ps2_pkg;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned BIT_IDX_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_BIT  = 2'd2,
        ST_GAP  = 2'd3
    } ps2_state_e;

    // Bit that makes the total count of ones across data+parity odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous scan-code FIFO with async reset and occupancy output; push ignored when full.
module ps2_tx_fifo #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ps2_frame_generator.sv
// PS/2 device-side transmitter: queues scan codes and serialises each as an 11-bit frame.
// Optional PS2_PAR_ERR_INJ_EN adds inj_par_err to invert the parity bit of a frame.
module ps2_frame_generator
    import ps2_pkg::*;
#(
    parameter  int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter  int unsigned PS2_FREQ_HZ = 12_500,
    parameter  int unsigned FIFO_DEPTH  = 8,
    parameter  int unsigned GAP_BITS    = 8,
    localparam int unsigned LW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          wr_valid,
    input  logic [7:0]    wr_data,
    output logic          wr_ready,
    output logic [LW-1:0] fifo_level,
    output logic          ps2_clk_out,
    output logic          ps2_data_out,
    output logic          busy,
    output logic          frame_done
`ifdef PS2_PAR_ERR_INJ_EN
    ,
    input  logic          inj_par_err
`endif
);

    localparam int unsigned HALF       = CLK_FREQ_HZ / (2 * PS2_FREQ_HZ);
    localparam int unsigned HW         = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned GAP_CYCLES = GAP_BITS * 2 * HALF;
    localparam int unsigned GW         = (GAP_CYCLES > 3) ? $clog2(GAP_CYCLES) : 2;
    localparam int unsigned SR_W       = PS2_FRAME_BITS - 1;

    if (HALF < 2) begin : g_half_chk
        $error("ps2_frame_generator: HALF must be >= 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("ps2_frame_generator: FIFO_DEPTH must be a power of two >= 2");
    end
    if (GAP_BITS < 1) begin : g_gap_chk
        $error("ps2_frame_generator: GAP_BITS must be >= 1");
    end

    ps2_state_e          state;
    logic [HW-1:0]       half_cnt;
    logic                phase_low;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic [GW-1:0]       gap_cnt;
    logic [SR_W-1:0]     frame_sr;
    logic [7:0]          fifo_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic                par_flip;

`ifdef PS2_PAR_ERR_INJ_EN
    assign par_flip = inj_par_err;
`else
    assign par_flip = 1'b0;
`endif

    assign wr_ready = !fifo_full;
    assign fifo_pop = (state == ST_LOAD);

    ps2_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // The LOAD cycle doubles as the final gap cycle, so back-to-back frames keep the nominal period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            ps2_clk_out  <= 1'b1;
            ps2_data_out <= 1'b1;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            half_cnt     <= '0;
            phase_low    <= 1'b0;
            bit_idx      <= '0;
            gap_cnt      <= '0;
            frame_sr     <= '1;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ena && !fifo_empty) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    frame_sr     <= {1'b1, odd_parity(fifo_data) ^ par_flip, fifo_data};
                    ps2_data_out <= 1'b0;
                    ps2_clk_out  <= 1'b1;
                    half_cnt     <= '0;
                    phase_low    <= 1'b0;
                    bit_idx      <= '0;
                    state        <= ST_BIT;
                end
                ST_BIT: begin
                    if (half_cnt == HW'(HALF - 1)) begin
                        half_cnt <= '0;
                        if (!phase_low) begin
                            phase_low   <= 1'b1;
                            ps2_clk_out <= 1'b0;
                        end else begin
                            phase_low   <= 1'b0;
                            ps2_clk_out <= 1'b1;
                            if (bit_idx == BIT_IDX_W'(PS2_FRAME_BITS - 1)) begin
                                state        <= ST_GAP;
                                frame_done   <= 1'b1;
                                ps2_data_out <= 1'b1;
                                gap_cnt      <= '0;
                            end else begin
                                bit_idx      <= bit_idx + 1'b1;
                                ps2_data_out <= frame_sr[0];
                                frame_sr     <= {1'b1, frame_sr[SR_W-1:1]};
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 2)) begin
                        if (ena && !fifo_empty) begin
                            state <= ST_LOAD;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_frame_generator.sv
// Directed self-checking bench for ps2_frame_generator with shortened timing (HALF=5, GAP_BITS=2).
module tb_ps2_frame_generator;

    localparam int unsigned HALF_T   = 5;
    localparam int unsigned GAP_T    = 2 * 2 * HALF_T;
    localparam int unsigned PERIOD_T = (11 + 2) * 2 * HALF_T;
    localparam int          TMO      = 400;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic [3:0] fifo_level;
    logic       ps2_clk_out;
    logic       ps2_data_out;
    logic       busy;
    logic       frame_done;
`ifdef PS2_PAR_ERR_INJ_EN
    logic       inj_par_err = 1'b0;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int fd_cnt  = 0;

    ps2_frame_generator #(
        .CLK_FREQ_HZ (40),
        .PS2_FREQ_HZ (4),
        .FIFO_DEPTH  (8),
        .GAP_BITS    (2)
    ) dut (
`ifdef PS2_PAR_ERR_INJ_EN
        .inj_par_err  (inj_par_err),
`endif
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .fifo_level   (fifo_level),
        .ps2_clk_out  (ps2_clk_out),
        .ps2_data_out (ps2_data_out),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] code);
        wr_data  = code;
        wr_valid = 1'b1;
        step(1);
        wr_valid = 1'b0;
    endtask

    task automatic wait_start(output int ts, output bit ok);
        ok = 1'b0;
        ts = 0;
        for (int n = 0; n < TMO; n++) begin
            if (ps2_data_out == 1'b0) begin
                ok = 1'b1;
                ts = cyc;
                return;
            end
            step(1);
        end
    endtask

    // Returns the 11 data values seen at successive ps2_clk_out falling edges.
    task automatic get_frame(output logic [10:0] f, output int ts, output int tf, output bit ok);
        logic prev;
        bit   found;
        f  = '0;
        tf = 0;
        wait_start(ts, ok);
        if (!ok) return;
        for (int i = 0; i < 11; i++) begin
            found = 1'b0;
            for (int n = 0; n < TMO && !found; n++) begin
                prev = ps2_clk_out;
                step(1);
                if (prev && !ps2_clk_out) found = 1'b1;
            end
            if (!found) begin
                ok = 1'b0;
                return;
            end
            f[i] = ps2_data_out;
            if (i == 0) tf = cyc;
        end
    endtask

    task automatic watch_quiet(input int n, output bit low_seen);
        low_seen = 1'b0;
        repeat (n) begin
            step(1);
            if (ps2_data_out !== 1'b1) low_seen = 1'b1;
        end
    endtask

    logic [10:0] f;
    int          ts, tf, acc, prev_ts, fd0;
    bit          ok, found, low_seen;
    logic [7:0]  codes3 [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    logic        pars3  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0]  codes2 [3] = '{8'h21, 8'hF0, 8'h5A};

    initial begin
        // Reset state
        step(3);
        check("rst_clk", 32'(ps2_clk_out), 32'd1);
        check("rst_data", 32'(ps2_data_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ready", 32'(wr_ready), 32'd1);
        rst_n = 1'b1;
        step(2);

        // Single frame 0x1C: latency, bit order, frame_done, gap length
        ena = 1'b1;
        push(8'h1C);
        acc = cyc;
        check("t1_level", 32'(fifo_level), 32'd1);
        get_frame(f, ts, tf, ok);
        check("t1_ok", 32'(ok), 32'd1);
        check("t1_frame", 32'(f), 32'({1'b1, 1'b0, 8'h1C, 1'b0}));
        check("t1_start_lat", 32'(ts - acc), 32'd2);
        check("t1_fall_lat", 32'(tf - ts), 32'(HALF_T));
        check("t1_busy", 32'(busy), 32'd1);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            step(1);
            if (frame_done) found = 1'b1;
        end
        check("t1_done_seen", 32'(found), 32'd1);
        check("t1_done_clk", 32'(ps2_clk_out), 32'd1);
        check("t1_done_at", 32'(cyc - ts), 32'(22 * HALF_T));
        step(GAP_T - 2);
        check("t1_gap_busy", 32'(busy), 32'd1);
        step(1);
        check("t1_gap_end", 32'(busy), 32'd0);
        check("t1_done_cnt", 32'(fd_cnt), 32'd1);

        // Back-to-back codes: simultaneous push/pop, parity, frame period
        push(codes2[0]);
        push(codes2[1]);
        push(codes2[2]);
        check("t2_level_pushpop", 32'(fifo_level), 32'd2);
        prev_ts = 0;
        for (int k = 0; k < 3; k++) begin
            get_frame(f, ts, tf, ok);
            check("t2_ok", 32'(ok), 32'd1);
            check("t2_frame", 32'(f), 32'({1'b1, 1'b1, codes2[k], 1'b0}));
            if (k > 0) check("t2_period", 32'(ts - prev_ts), 32'(PERIOD_T));
            prev_ts = ts;
        end
        step(40);

        // Fill with ena=0, overflow dropped, then drain
        ena = 1'b0;
        for (int k = 0; k < 8; k++) push(codes3[k]);
        check("t3_ready_full", 32'(wr_ready), 32'd0);
        check("t3_level_full", 32'(fifo_level), 32'd8);
        push(8'hAA);
        check("t3_level_drop", 32'(fifo_level), 32'd8);
        check("t3_idle_busy", 32'(busy), 32'd0);
        fd0 = fd_cnt;
        ena = 1'b1;
        for (int k = 0; k < 8; k++) begin
            get_frame(f, ts, tf, ok);
            check("t3_ok", 32'(ok), 32'd1);
            check("t3_frame", 32'(f), 32'({1'b1, pars3[k], codes3[k], 1'b0}));
        end
        step(200);
        check("t3_frames", 32'(fd_cnt - fd0), 32'd8);
        check("t3_level_empty", 32'(fifo_level), 32'd0);

        // Async reset in slot 5 (clock-low phase) abandons frame and queue
        push(8'h32);
        push(8'h44);
        wait_start(ts, ok);
        check("t4_ok", 32'(ok), 32'd1);
        step(5 * 2 * HALF_T + 7);
        check("t4_pre_clk", 32'(ps2_clk_out), 32'd0);
        fd0 = fd_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_rst_clk", 32'(ps2_clk_out), 32'd1);
        check("t4_rst_data", 32'(ps2_data_out), 32'd1);
        check("t4_rst_level", 32'(fifo_level), 32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        watch_quiet(300, low_seen);
        check("t4_no_frame", 32'(low_seen), 32'd0);
        check("t4_no_done", 32'(fd_cnt - fd0), 32'd0);

        // ena dropped in slot 3: frame and gap finish, second code stays queued
        push(8'h5A);
        push(8'h21);
        wait_start(ts, ok);
        check("t5_ok", 32'(ok), 32'd1);
        fd0 = fd_cnt;
        step(3 * 2 * HALF_T + 2);
        ena = 1'b0;
        found = 1'b0;
        for (int n = 0; n < TMO && !found; n++) begin
            step(1);
            if (!busy) found = 1'b1;
        end
        check("t5_idle", 32'(found), 32'd1);
        check("t5_end_at", 32'(cyc - ts), 32'(PERIOD_T - 1));
        check("t5_done", 32'(fd_cnt - fd0), 32'd1);
        check("t5_level", 32'(fifo_level), 32'd1);
        watch_quiet(200, low_seen);
        check("t5_hold", 32'(low_seen), 32'd0);
        ena = 1'b1;
        get_frame(f, ts, tf, ok);
        check("t5_resume", 32'(f), 32'({1'b1, 1'b1, 8'h21, 1'b0}));
        step(40);

`ifdef PS2_PAR_ERR_INJ_EN
        // Parity inversion on demand
        inj_par_err = 1'b1;
        push(8'h1C);
        step(2);
        inj_par_err = 1'b0;
        get_frame(f, ts, tf, ok);
        check("t6_inj", 32'(f), 32'({1'b1, 1'b1, 8'h1C, 1'b0}));
        step(40);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
